// File: rtl/fixed8_word_packer.sv
// Quantises signed Q7.8 samples to int8 with round-half-away and saturation, then packs
// LANES of them per output word on a valid/ready stream; flush closes a partial word.
module fixed8_word_packer #(
    parameter int LANES = 4,
    parameter int SHIFT = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [2:0]           out_bytes,
    output logic                 out_last,
    input  logic                 sat_clr,
    output logic [CNT_W-1:0]     sat_cnt
);
    localparam int W   = 8 * LANES;
    localparam int CW  = $clog2(LANES + 1);
    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [16:0] HALF = (SHIFT > 0) ? (17'sd1 <<< SH1) : 17'sd0;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH_PEND} state_t;

    state_t                 state;
    logic [CW-1:0]          lane_cnt;
    logic [W-1:0]           asm_p0;

    logic signed [16:0]     rnd_p0;
    logic signed [7:0]      q_p0;
    logic                   sat_p0;
    logic                   accept;
    logic                   complete;
    logic                   out_free;
    logic [CW-1:0]          lc_acc;
    logic [W-1:0]           asm_nxt;

    // Negative values get a bias one smaller so exact halves round away from zero.
    function automatic logic signed [16:0] round_shift(input logic signed [15:0] x);
        logic signed [16:0] xe;
        xe = {x[15], x};
        if (SHIFT == 0) return xe;
        return (x[15] ? (xe + HALF - 17'sd1) : (xe + HALF)) >>> SHIFT;
    endfunction

    function automatic logic is_sat(input logic signed [16:0] v);
        return (v > 17'sd127) || (v < -17'sd128);
    endfunction

    function automatic logic signed [7:0] clamp8(input logic signed [16:0] v);
        if (v > 17'sd127)       return 8'sd127;
        else if (v < -17'sd128) return -8'sd128;
        else                    return v[7:0];
    endfunction

    // Depends only on registered state, so out_ready never reaches in_ready combinationally.
    assign in_ready = !(out_valid && (lane_cnt == CW'(LANES - 1))) && (state != FLUSH_PEND);

    // Stage p0: quantise and merge the incoming sample into the assembly word
    always_comb begin
        rnd_p0   = round_shift(in_data);
        q_p0     = clamp8(rnd_p0);
        sat_p0   = is_sat(rnd_p0);
        accept   = in_valid && in_ready;
        complete = accept && (lane_cnt == CW'(LANES - 1));
        lc_acc   = lane_cnt + CW'(accept);
        out_free = !out_valid || out_ready;
        asm_nxt  = asm_p0;
        for (int i = 0; i < LANES; i++) begin
            if (accept && (lane_cnt == CW'(i))) asm_nxt[i*8 +: 8] = q_p0;
        end
    end

    // Stage p1: output word register, flush sequencing and saturation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane_cnt  <= '0;
            asm_p0    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_last  <= 1'b0;
            sat_cnt   <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (state == FLUSH_PEND) begin
                if (out_free) begin
                    out_valid <= 1'b1;
                    out_data  <= asm_p0;
                    out_bytes <= 3'(lane_cnt);
                    out_last  <= 1'b1;
                    asm_p0    <= '0;
                    lane_cnt  <= '0;
                    state     <= IDLE;
                end
            end else if (complete) begin
                out_valid <= 1'b1;
                out_data  <= asm_nxt;
                out_bytes <= 3'(LANES);
                out_last  <= flush;
                asm_p0    <= '0;
                lane_cnt  <= '0;
                state     <= IDLE;
            end else if (flush && (lc_acc != '0)) begin
                if (out_free) begin
                    out_valid <= 1'b1;
                    out_data  <= asm_nxt;
                    out_bytes <= 3'(lc_acc);
                    out_last  <= 1'b1;
                    asm_p0    <= '0;
                    lane_cnt  <= '0;
                    state     <= IDLE;
                end else begin
                    asm_p0   <= asm_nxt;
                    lane_cnt <= lc_acc;
                    state    <= FLUSH_PEND;
                end
            end else if (accept) begin
                asm_p0   <= asm_nxt;
                lane_cnt <= lc_acc;
                state    <= FILL;
            end

            if (sat_clr)                                 sat_cnt <= '0;
            else if (accept && sat_p0 && (sat_cnt != '1)) sat_cnt <= sat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fixed8_word_packer.sv
// Scoreboard bench for fixed8_word_packer: a reference quantiser builds expected words,
// which a negedge monitor pops and compares on every output handshake.
module tb_fixed8_word_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } word_t;

    word_t       sb[$];
    logic [31:0] m_word = '0;
    int          m_cnt = 0;
    int          sat_exp = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    fixed8_word_packer #(.LANES(4), .SHIFT(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bytes(out_bytes), .out_last(out_last),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    // Reference: round half away from zero on magnitudes, then clamp.
    function automatic logic [7:0] ref_q(input logic [15:0] x, output bit sat);
        int v, r;
        v = int'($signed(x));
        if (v >= 0) r = (v + 128) / 256;
        else        r = -((-v + 128) / 256);
        sat = (r > 127) || (r < -128);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    task automatic model_accept(input logic [15:0] x, input logic fl);
        bit s;
        logic [7:0] q;
        q = ref_q(x, s);
        if (s) sat_exp++;
        m_word[m_cnt*8 +: 8] = q;
        m_cnt++;
        if (m_cnt == 4) begin
            sb.push_back('{data: m_word, bytes: 3'd4, last: fl});
            m_word = '0;
            m_cnt = 0;
        end else if (fl) begin
            sb.push_back('{data: m_word, bytes: 3'(m_cnt), last: 1'b1});
            m_word = '0;
            m_cnt = 0;
        end
    endtask

    // Called just after a posedge; returns just after the posedge that accepted the sample.
    task automatic send(input logic [15:0] x, input logic fl);
        int n;
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 60) begin
                tests++; fails++;
                $display("FAIL send_timeout: in_ready=%0b required 1 for data %h", in_ready, x);
                in_valid = 1'b0;
                return;
            end
        end
        flush = fl;
        model_accept(x, fl);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        if (m_cnt > 0) begin
            sb.push_back('{data: m_word, bytes: 3'(m_cnt), last: 1'b1});
            m_word = '0;
            m_cnt = 0;
        end
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (sb.size() != 0 || out_valid) begin
            fails++;
            $display("FAIL drain: pending=%0d out_valid=%0b required 0/0", sb.size(), out_valid);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word: data=%h bytes=%0d last=%0b required no word",
                         out_data, out_bytes, out_last);
            end else begin
                word_t e;
                e = sb.pop_front();
                if (out_data !== e.data || out_bytes !== e.bytes || out_last !== e.last) begin
                    fails++;
                    $display("FAIL word: data=%h bytes=%0d last=%0b required data=%h bytes=%0d last=%0b",
                             out_data, out_bytes, out_last, e.data, e.bytes, e.last);
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_bytes !== '0 || out_last !== 1'b0 || sat_cnt !== '0) begin
            fails++;
            $display("FAIL reset_outputs: v=%0b d=%h b=%0d l=%0b s=%0d required all 0",
                     out_valid, out_data, out_bytes, out_last, sat_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: in_ready=%0b required 1", in_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) send(16'h0100, 1'b0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h01010101 || out_bytes !== 3'd4 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL basic_latency: v=%0b d=%h b=%0d l=%0b required 1 01010101 4 0",
                     out_valid, out_data, out_bytes, out_last);
        end
        wait_drain();
    endtask

    task automatic test_rounding();
        logic [15:0] v[8] = '{16'h0180, 16'hFE80, 16'h0080, 16'hFF80,
                              16'h007F, 16'hFF81, 16'h017F, 16'hFE7F};
        for (int i = 0; i < 4; i++) send(v[i], 1'b0);
        tests++;
        if (out_data !== 32'hFF01FE02) begin
            fails++;
            $display("FAIL rounding_word: data=%h required ff01fe02", out_data);
        end
        for (int i = 4; i < 8; i++) send(v[i], 1'b0);
        wait_drain();
    endtask

    task automatic test_saturation();
        logic [15:0] v[8] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000,
                              16'h7F80, 16'h8000, 16'h0100, 16'hFF00};
        for (int i = 0; i < 8; i++) send(v[i], 1'b0);
        tests++;
        if (sat_cnt !== 16'(sat_exp)) begin
            fails++;
            $display("FAIL sat_cnt: got %0d required %0d", sat_cnt, sat_exp);
        end
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        sat_exp = 0;
        tests++;
        if (sat_cnt !== 16'd0) begin
            fails++;
            $display("FAIL sat_clr: got %0d required 0", sat_cnt);
        end
        wait_drain();
    endtask

    task automatic test_flush();
        send(16'h0300, 1'b0);
        send(16'h0500, 1'b0);
        do_flush();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000503 || out_bytes !== 3'd2 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL flush_partial: v=%0b d=%h b=%0d l=%0b required 1 00000503 2 1",
                     out_valid, out_data, out_bytes, out_last);
        end
        wait_drain();
        do_flush();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_empty: out_valid=%0b required 0", out_valid);
        end
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        send(16'h0300, 1'b0);
        send(16'h0400, 1'b1);
        send(16'h0700, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(16'((i + 1) * 256), 1'b0);
        held = out_data;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_in_ready: in_ready=%0b required 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== held || out_data !== 32'h04030201) begin
            fails++;
            $display("FAIL bp_stable: v=%0b d=%h required 1 04030201", out_valid, out_data);
        end
        out_ready = 1'b1;
        send(16'h0800, 1'b0);
        wait_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(16'(16'h0A00 + i * 256), 1'b0);
        do_flush();
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_flush_pend: in_ready=%0b required 0", in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 3) != 0;
            send(16'($urandom_range(0, 16'hFFFF)), 1'b0);
        end
        out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        send(16'h0100, 1'b0);
        send(16'h7FFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        sb.delete();
        m_word = '0;
        m_cnt = 0;
        sat_exp = 0;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_bytes !== '0 || out_last !== 1'b0 || sat_cnt !== '0) begin
            fails++;
            $display("FAIL reset_mid: v=%0b d=%h b=%0d l=%0b s=%0d required all 0",
                     out_valid, out_data, out_bytes, out_last, sat_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(16'h0200, 1'b0);
        tests++;
        if (out_data !== 32'h02020202 || out_bytes !== 3'd4) begin
            fails++;
            $display("FAIL reset_fresh_word: d=%h b=%0d required 02020202 4", out_data, out_bytes);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
